// File: rtl/ram_arb_2p.sv
// Two-requester round-robin arbiter in front of a single-port RAM.
// It issues combinational grants and returns a fixed-latency-1 response with an out-of-range error flag.
module ram_arb_2p #(
    parameter int AW     = 13,
    parameter int NWORDS = 6144
) (
    input  logic          CLK,
    input  logic          RST,

    input  logic          R0_REQ,
    input  logic [3:0]    R0_WE,
    input  logic [AW-1:0] R0_A,
    input  logic [31:0]   R0_DI,
    output logic          R0_GNT,
    output logic          R0_RVALID,
    output logic [31:0]   R0_RDATA,
    output logic          R0_ERR,

    input  logic          R1_REQ,
    input  logic [3:0]    R1_WE,
    input  logic [AW-1:0] R1_A,
    input  logic [31:0]   R1_DI,
    output logic          R1_GNT,
    output logic          R1_RVALID,
    output logic [31:0]   R1_RDATA,
    output logic          R1_ERR,

    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_DI,
    input  logic [31:0]   RAM_DO,

    output logic [15:0]   CONFLICTS
);

    localparam logic [31:0] NWORDS_U = 32'(NWORDS);

    logic          ptr;
    logic          gnt0;
    logic          gnt1;
    logic          any_gnt;
    logic          in_range;
    logic [AW-1:0] sel_a;
    logic [3:0]    sel_we;
    logic [31:0]   sel_di;

    logic          rsp_valid;
    logic          rsp_owner;
    logic          rsp_read;
    logic          rsp_err;
    logic          rsp_live;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        gnt0    = !RST && R0_REQ && (!R1_REQ || !ptr);
        gnt1    = !RST && R1_REQ && (!R0_REQ ||  ptr);
        any_gnt = gnt0 || gnt1;
        sel_a   = gnt1 ? R1_A  : R0_A;
        sel_we  = gnt1 ? R1_WE : R0_WE;
        sel_di  = gnt1 ? R1_DI : R0_DI;
        in_range = 32'(sel_a) < NWORDS_U;
    end

    always_comb begin
        RAM_EN = 1'b0;
        RAM_WE = '0;
        RAM_A  = '0;
        RAM_DI = '0;
        if (any_gnt && in_range) begin
            RAM_EN = 1'b1;
            RAM_WE = sel_we;
            RAM_A  = sel_a;
            RAM_DI = sel_di;
        end
    end

    assign R0_GNT = gnt0;
    assign R1_GNT = gnt1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
            rsp_read  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= any_gnt;
            if (any_gnt) begin
                ptr       <= gnt0;
                rsp_owner <= gnt1;
                rsp_read  <= (sel_we == 4'b0000);
                rsp_err   <= !in_range;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            CONFLICTS <= '0;
        end else if (R0_REQ && R1_REQ && (CONFLICTS != 16'hFFFF)) begin
            CONFLICTS <= CONFLICTS + 16'd1;
        end
    end

    // A response pending while RST is high belongs to a transaction being discarded.
    always_comb begin
        rsp_live  = rsp_valid && !RST;
        R0_RVALID = rsp_live && !rsp_owner;
        R1_RVALID = rsp_live &&  rsp_owner;
        R0_ERR    = R0_RVALID && rsp_err;
        R1_ERR    = R1_RVALID && rsp_err;
        R0_RDATA  = (R0_RVALID && rsp_read && !rsp_err) ? RAM_DO : 32'h0;
        R1_RDATA  = (R1_RVALID && rsp_read && !rsp_err) ? RAM_DO : 32'h0;
    end

endmodule

// File: tb/tb_ram_arb_2p.sv
// Directed testbench for ram_arb_2p with a byte-enabled, zero-initialised RAM model.
module tb_ram_arb_2p;

    localparam int AW     = 13;
    localparam int NWORDS = 6144;

    logic          CLK;
    logic          RST;
    logic          R0_REQ, R1_REQ;
    logic [3:0]    R0_WE, R1_WE;
    logic [AW-1:0] R0_A, R1_A;
    logic [31:0]   R0_DI, R1_DI;
    logic          R0_GNT, R1_GNT;
    logic          R0_RVALID, R1_RVALID;
    logic [31:0]   R0_RDATA, R1_RDATA;
    logic          R0_ERR, R1_ERR;
    logic          RAM_EN;
    logic [3:0]    RAM_WE;
    logic [AW-1:0] RAM_A;
    logic [31:0]   RAM_DI;
    logic [31:0]   RAM_DO;
    logic [15:0]   CONFLICTS;

    int tests_run;
    int tests_failed;
    int resp_count;

    logic [31:0] mem [NWORDS];

    ram_arb_2p #(.AW(AW), .NWORDS(NWORDS)) dut (
        .CLK(CLK), .RST(RST),
        .R0_REQ(R0_REQ), .R0_WE(R0_WE), .R0_A(R0_A), .R0_DI(R0_DI),
        .R0_GNT(R0_GNT), .R0_RVALID(R0_RVALID), .R0_RDATA(R0_RDATA), .R0_ERR(R0_ERR),
        .R1_REQ(R1_REQ), .R1_WE(R1_WE), .R1_A(R1_A), .R1_DI(R1_DI),
        .R1_GNT(R1_GNT), .R1_RVALID(R1_RVALID), .R1_RDATA(R1_RDATA), .R1_ERR(R1_ERR),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_DI(RAM_DI),
        .RAM_DO(RAM_DO), .CONFLICTS(CONFLICTS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Registered-read RAM: data for an access appears the cycle after RAM_EN.
    always @(posedge CLK) begin
        if (RAM_EN && (int'(RAM_A) < NWORDS)) begin
            RAM_DO <= mem[RAM_A];
            for (int b = 0; b < 4; b++)
                if (RAM_WE[b]) mem[RAM_A][8*b +: 8] <= RAM_DI[8*b +: 8];
        end
    end

    // Inputs change 1 time unit after the edge; outputs are checked 1 unit later.
    task automatic apply_stimulus(input logic rst,
                                  input logic r0_req, input logic [3:0] r0_we,
                                  input logic [AW-1:0] r0_a, input logic [31:0] r0_di,
                                  input logic r1_req, input logic [3:0] r1_we,
                                  input logic [AW-1:0] r1_a, input logic [31:0] r1_di);
        @(posedge CLK);
        #1;
        RST    = rst;
        R0_REQ = r0_req; R0_WE = r0_we; R0_A = r0_a; R0_DI = r0_di;
        R1_REQ = r1_req; R1_WE = r1_we; R1_A = r1_a; R1_DI = r1_di;
        #1;
    endtask

    task automatic idle(input logic rst);
        apply_stimulus(rst, 1'b0, 4'h0, '0, 32'h0, 1'b0, 4'h0, '0, 32'h0);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        resp_count   = 0;
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'h0;
        mem[5]    = 32'hDEAD_0005;
        mem[1030] = 32'h1030_BEEF;
        RAM_DO = 32'h0;
        RST = 1'b1;
        R0_REQ = 1'b0; R0_WE = 4'h0; R0_A = '0; R0_DI = 32'h0;
        R1_REQ = 1'b0; R1_WE = 4'h0; R1_A = '0; R1_DI = 32'h0;

        // Reset with both requesting: no grants, no RAM access
        idle(1'b1);
        apply_stimulus(1'b1, 1'b1, 4'h0, 13'd5, 32'h0, 1'b1, 4'h0, 13'd1030, 32'h0);
        check_output("rst_r0_gnt", 32'(R0_GNT), 32'd0);
        check_output("rst_r1_gnt", 32'(R1_GNT), 32'd0);
        check_output("rst_ram_en", 32'(RAM_EN), 32'd0);

        // Tie after reset
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd5, 32'h0, 1'b1, 4'h0, 13'd1030, 32'h0);
        check_output("rst_r0_rvalid", 32'(R0_RVALID), 32'd0);
        check_output("rst_r1_rvalid", 32'(R1_RVALID), 32'd0);
        check_output("rst_conflicts", 32'(CONFLICTS), 32'd0);
        check_output("tie_c0_r0_gnt", 32'(R0_GNT), 32'd1);
        check_output("tie_c0_r1_gnt", 32'(R1_GNT), 32'd0);
        check_output("tie_c0_ram_en", 32'(RAM_EN), 32'd1);
        check_output("tie_c0_ram_a", 32'(RAM_A), 32'd5);
        apply_stimulus(1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 13'd1030, 32'h0);
        check_output("tie_c1_r0_rvalid", 32'(R0_RVALID), 32'd1);
        check_output("tie_c1_r0_rdata", R0_RDATA, 32'hDEAD_0005);
        check_output("tie_c1_r1_gnt", 32'(R1_GNT), 32'd1);
        check_output("tie_c1_ram_a", 32'(RAM_A), 32'd1030);
        check_output("tie_c1_conflicts", 32'(CONFLICTS), 32'd1);
        idle(1'b0);
        check_output("tie_c2_r1_rvalid", 32'(R1_RVALID), 32'd1);
        check_output("tie_c2_r1_rdata", R1_RDATA, 32'h1030_BEEF);
        check_output("tie_c2_r0_rvalid", 32'(R0_RVALID), 32'd0);
        check_output("tie_c2_ram_en", 32'(RAM_EN), 32'd0);
        check_output("tie_c2_conflicts", 32'(CONFLICTS), 32'd1);

        // Write then back-to-back read at the top in-range address
        apply_stimulus(1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1, 4'b0011, 13'd6143, 32'hA5A5_1234);
        check_output("wr_r1_gnt", 32'(R1_GNT), 32'd1);
        check_output("wr_ram_en", 32'(RAM_EN), 32'd1);
        check_output("wr_ram_we", 32'(RAM_WE), 32'h3);
        check_output("wr_ram_di", RAM_DI, 32'hA5A5_1234);
        apply_stimulus(1'b0, 1'b0, 4'h0, '0, 32'h0, 1'b1, 4'h0, 13'd6143, 32'h0);
        check_output("wr_r1_rvalid", 32'(R1_RVALID), 32'd1);
        check_output("wr_r1_rdata", R1_RDATA, 32'h0);
        check_output("wr_r1_err", 32'(R1_ERR), 32'd0);
        check_output("rd_r1_gnt", 32'(R1_GNT), 32'd1);
        check_output("rd_ram_we", 32'(RAM_WE), 32'h0);
        idle(1'b0);
        check_output("rd_r1_rvalid", 32'(R1_RVALID), 32'd1);
        check_output("rd_r1_rdata", R1_RDATA, 32'h0000_1234);

        // Out-of-range reads
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd6144, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        check_output("oor1_r0_gnt", 32'(R0_GNT), 32'd1);
        check_output("oor1_ram_en", 32'(RAM_EN), 32'd0);
        check_output("oor1_ram_a", 32'(RAM_A), 32'd0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd8191, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        check_output("oor1_r0_rvalid", 32'(R0_RVALID), 32'd1);
        check_output("oor1_r0_err", 32'(R0_ERR), 32'd1);
        check_output("oor1_r0_rdata", R0_RDATA, 32'h0);
        check_output("oor2_r0_gnt", 32'(R0_GNT), 32'd1);
        check_output("oor2_ram_en", 32'(RAM_EN), 32'd0);
        idle(1'b0);
        check_output("oor2_r0_rvalid", 32'(R0_RVALID), 32'd1);
        check_output("oor2_r0_err", 32'(R0_ERR), 32'd1);
        check_output("oor2_r0_rdata", R0_RDATA, 32'h0);
        check_output("oor2_r1_err", 32'(R1_ERR), 32'd0);

        // Alternation from a fresh reset
        idle(1'b1);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b1, 4'h0, 13'd20, 32'h0, 1'b1, 4'h0, 13'd21, 32'h0);
            check_output($sformatf("alt%0d_r0_gnt", i), 32'(R0_GNT), 32'((i % 2) == 0));
            check_output($sformatf("alt%0d_r1_gnt", i), 32'(R1_GNT), 32'((i % 2) == 1));
            if (i > 0) begin
                check_output($sformatf("alt%0d_rvalid", i),
                             {30'h0, R1_RVALID, R0_RVALID},
                             ((i % 2) == 1) ? 32'b01 : 32'b10);
                if (R0_RVALID || R1_RVALID) resp_count++;
            end
        end
        idle(1'b0);
        check_output("alt_last_r1_rvalid", 32'(R1_RVALID), 32'd1);
        if (R0_RVALID || R1_RVALID) resp_count++;
        check_output("alt_resp_count", 32'(resp_count), 32'd10);
        check_output("alt_conflicts", 32'(CONFLICTS), 32'd10);

        // Reset right after an R0 grant
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd5, 32'h0, 1'b0, 4'h0, '0, 32'h0);
        check_output("mid_r0_gnt", 32'(R0_GNT), 32'd1);
        idle(1'b1);
        check_output("mid_rst_r0_rvalid", 32'(R0_RVALID), 32'd0);
        check_output("mid_rst_r0_rdata", R0_RDATA, 32'h0);
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd5, 32'h0, 1'b1, 4'h0, 13'd6, 32'h0);
        check_output("mid_post_r0_rvalid", 32'(R0_RVALID), 32'd0);
        check_output("mid_post_conflicts", 32'(CONFLICTS), 32'd0);
        check_output("mid_post_r0_gnt", 32'(R0_GNT), 32'd1);
        check_output("mid_post_r1_gnt", 32'(R1_GNT), 32'd0);

        // Saturation: 70000 conflict cycles on top of the one above
        for (int i = 0; i < 70000; i++)
            apply_stimulus(1'b0, 1'b1, 4'h0, 13'd5, 32'h0, 1'b1, 4'h0, 13'd6, 32'h0);
        check_output("sat_conflicts", 32'(CONFLICTS), 32'h0000_FFFF);
        apply_stimulus(1'b0, 1'b1, 4'h0, 13'd5, 32'h0, 1'b1, 4'h0, 13'd6, 32'h0);
        check_output("sat_hold_conflicts", 32'(CONFLICTS), 32'h0000_FFFF);
        idle(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ram_arb_2p.md
RAM_ARB_2P -- requirements
Module: ram_arb_2p

Interface
REQ-001 SHALL have parameter AW, default 13, meaning the word-address width.
REQ-002 SHALL have parameter NWORDS, default 6144, meaning the number of implemented words; addresses >= NWORDS are out of range.
REQ-003 SHALL have port CLK, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports R0_REQ / R1_REQ, input, 1, requester i has a transaction pending.
REQ-006 SHALL have ports R0_WE / R1_WE, input, 4, byte write enables; 4'b0000 means read.
REQ-007 SHALL have ports R0_A / R1_A, input, AW, word address.
REQ-008 SHALL have ports R0_DI / R1_DI, input, 32, write data.
REQ-009 SHALL have ports R0_GNT / R1_GNT, output, 1, combinational accept; the transaction transfers when REQ and GNT are both high at the edge.
REQ-010 SHALL have ports R0_RVALID / R1_RVALID, output, 1, one-cycle response strobe.
REQ-011 SHALL have ports R0_RDATA / R1_RDATA, output, 32, read data, valid with RVALID.
REQ-012 SHALL have ports R0_ERR / R1_ERR, output, 1, out-of-range flag, valid with RVALID.
REQ-013 SHALL have ports RAM_EN (output, 1), RAM_WE (output, 4), RAM_A (output, AW) and RAM_DI (output, 32), which drive the shared RAM.
REQ-014 SHALL have port RAM_DO, input, 32, RAM read data, valid the cycle after RAM_EN.
REQ-015 SHALL have port CONFLICTS, output, 16, saturating count of cycles in which both REQ inputs are high.

Function
REQ-016 SHALL assert at most one GNT per cycle, and only to a requester whose REQ is high.
REQ-017 SHALL grant the only requester when exactly one REQ is high, regardless of the pointer.
REQ-018 SHALL grant the requester named by a 1-bit round-robin pointer when both REQs are high.
REQ-019 SHALL set the pointer to the non-granted requester after every grant, and SHALL leave it unchanged in cycles without a grant.
REQ-020 SHALL, in a grant cycle with in-range address, drive combinationally: RAM_EN=1, RAM_WE=granted WE, RAM_A=granted A, RAM_DI=granted DI.
REQ-021 SHALL drive RAM_EN=0, RAM_WE=0, RAM_A=0 and RAM_DI=0 in cycles without an in-range grant.
REQ-022 SHALL, on an out-of-range grant (A >= NWORDS), accept the transaction but keep RAM_EN=0.
REQ-023 SHALL register the owner, the read/write kind and the error status of each grant into a one-stage response register.
REQ-024 SHALL pulse RVALID of the owner for exactly one cycle, in the cycle after the grant, for reads and writes alike (fixed latency 1).
REQ-025 SHALL present RDATA = RAM_DO for an in-range read, and RDATA = 0 for writes and out-of-range accesses.
REQ-026 SHALL present ERR = 1 only for out-of-range accesses.
REQ-027 SHALL drive RDATA=0 and ERR=0 whenever that requester's RVALID is 0.
REQ-028 SHALL sustain back-to-back grants, one per cycle; the response of grant N and the RAM access of grant N+1 occur in the same cycle.
REQ-029 SHALL increment CONFLICTS in every cycle with both REQs high, and SHALL hold it at 16'hFFFF once saturated.
REQ-030 SHALL treat REQ deassertion before GNT as a withdrawal, with no response and no state change; requesters hold WE/A/DI stable while REQ is high.

Reset
REQ-031 SHALL, in every cycle where RST is sampled high, hold all GNT=0 and RAM_EN=0.
REQ-032 SHALL, on the edge where RST is sampled high, clear the pointer to 0, CONFLICTS to 0 and the response register; all RVALID, ERR and RDATA are then 0.
REQ-033 SHALL suppress the response of a transaction granted in the cycle immediately before RST rises (no RVALID is issued).
REQ-034 SHALL grant normally in the first cycle after RST is deasserted, with requester 0 winning a tie.

Verification
REQ-035 SHALL verify tie after reset: R0 and R1 both read A=5 and A=1030 -> R0_GNT in cycle 0, R0_RVALID in cycle 1 with RAM_DO, R1_GNT in cycle 1, R1_RVALID in cycle 2; CONFLICTS=1.
REQ-036 SHALL verify write then read: R1 writes WE=4'b0011, DI=32'hA5A5_1234, A=6143 -> RAM_EN=1, R1_RVALID next cycle with RDATA=0 and ERR=0; a following R1 read of A=6143 -> RDATA=32'h0000_1234 (from a zero-initialised RAM model).
REQ-037 SHALL verify out-of-range: R0 reads A=6144 and then A=8191 -> RAM_EN stays 0, R0_RVALID=1 with ERR=1 and RDATA=0 each time.
REQ-038 SHALL verify alternation: both REQs held high for 10 cycles -> grants alternate R0,R1,R0,..., 10 responses, CONFLICTS=10.
REQ-039 SHALL verify saturation: both REQs held high for 70000 cycles -> CONFLICTS=16'hFFFF and stays there.
REQ-040 SHALL verify reset mid-operation: RST asserted the cycle after an R0 grant -> no R0_RVALID, pointer=0, CONFLICTS=0.
